// File: rtl/axi_pkg.sv
// Shared AXI definitions: arbiter state encodings, burst and response constants,
// and the fixed AXI field widths used by the read and write arbiters.
package axi_pkg;

  localparam int unsigned LEN_WIDTH   = 8;
  localparam int unsigned BEATS_WIDTH = LEN_WIDTH + 1;
  localparam int unsigned SIZE_WIDTH  = 3;
  localparam int unsigned BURST_WIDTH = 2;
  localparam int unsigned RESP_WIDTH  = 2;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_e;

  localparam logic [BURST_WIDTH-1:0] BURST_FIXED = 2'b00;
  localparam logic [BURST_WIDTH-1:0] BURST_INCR  = 2'b01;
  localparam logic [BURST_WIDTH-1:0] BURST_WRAP  = 2'b10;

  localparam logic [RESP_WIDTH-1:0] RESP_OKAY   = 2'b00;
  localparam logic [RESP_WIDTH-1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-requester round-robin pick: a tie goes to the requester that did not win last.
module rr_arbiter_2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       gnt_id
);

  always_comb begin
    gnt_valid = |req;
    gnt_id    = 1'b0;
    case (req)
      2'b10:   gnt_id = 1'b1;
      2'b11:   gnt_id = ~last_grant;
      default: gnt_id = 1'b0;
    endcase
  end

endmodule

// File: rtl/axi_read_arbiter.sv
// Two-master to one-slave AXI read arbiter: round-robin AR grant held for the whole
// burst, combinational R routing to the granted master, sticky rlast/beat-count check.
module axi_read_arbiter
  import axi_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 8,
  parameter int unsigned DATA_WIDTH    = 32
) (
  input  logic                     aclk,
  input  logic                     aresetn,

  input  logic [ADDRESS_WIDTH-1:0] m0_araddr,
  input  logic [LEN_WIDTH-1:0]     m0_arlen,
  input  logic [SIZE_WIDTH-1:0]    m0_arsize,
  input  logic [BURST_WIDTH-1:0]   m0_arburst,
  input  logic                     m0_arvalid,
  output logic                     m0_arready,
  output logic [DATA_WIDTH-1:0]    m0_rdata,
  output logic [RESP_WIDTH-1:0]    m0_rresp,
  output logic                     m0_rlast,
  output logic                     m0_rvalid,
  input  logic                     m0_rready,

  input  logic [ADDRESS_WIDTH-1:0] m1_araddr,
  input  logic [LEN_WIDTH-1:0]     m1_arlen,
  input  logic [SIZE_WIDTH-1:0]    m1_arsize,
  input  logic [BURST_WIDTH-1:0]   m1_arburst,
  input  logic                     m1_arvalid,
  output logic                     m1_arready,
  output logic [DATA_WIDTH-1:0]    m1_rdata,
  output logic [RESP_WIDTH-1:0]    m1_rresp,
  output logic                     m1_rlast,
  output logic                     m1_rvalid,
  input  logic                     m1_rready,

  output logic [ADDRESS_WIDTH-1:0] s_araddr,
  output logic [LEN_WIDTH-1:0]     s_arlen,
  output logic [SIZE_WIDTH-1:0]    s_arsize,
  output logic [BURST_WIDTH-1:0]   s_arburst,
  output logic                     s_arvalid,
  input  logic                     s_arready,
  input  logic [DATA_WIDTH-1:0]    s_rdata,
  input  logic [RESP_WIDTH-1:0]    s_rresp,
  input  logic                     s_rlast,
  input  logic                     s_rvalid,
  output logic                     s_rready,

  output logic                     grant_id,
  output logic                     busy,
  output logic                     burst_err
);

  arb_state_e             state, state_nxt;
  logic                   last_grant;
  logic [BEATS_WIDTH-1:0] beats_left;
  logic                   rr_valid, rr_id;
  logic                   sel_arvalid, sel_rready;
  logic                   r_hs;

  rr_arbiter_2 u_rr (
    .req        ({m1_arvalid, m0_arvalid}),
    .last_grant (last_grant),
    .gnt_valid  (rr_valid),
    .gnt_id     (rr_id)
  );

  // AR payload and handshake inputs follow the latched grant
  always_comb begin
    s_araddr    = grant_id ? m1_araddr  : m0_araddr;
    s_arlen     = grant_id ? m1_arlen   : m0_arlen;
    s_arsize    = grant_id ? m1_arsize  : m0_arsize;
    s_arburst   = grant_id ? m1_arburst : m0_arburst;
    sel_arvalid = grant_id ? m1_arvalid : m0_arvalid;
    sel_rready  = grant_id ? m1_rready  : m0_rready;
  end

  assign r_hs = (state == ARB_DATA) && s_rvalid && sel_rready;
  assign busy = (state != ARB_IDLE);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= ARB_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    s_arvalid  = 1'b0;
    m0_arready = 1'b0;
    m1_arready = 1'b0;
    s_rready   = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (rr_valid) state_nxt = ARB_ADDR;
      end
      ARB_ADDR: begin
        s_arvalid  = sel_arvalid;
        m0_arready = !grant_id && s_arready;
        m1_arready = grant_id && s_arready;
        if (sel_arvalid && s_arready) state_nxt = ARB_DATA;
      end
      ARB_DATA: begin
        s_rready = sel_rready;
        if (r_hs && s_rlast) state_nxt = ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  // R beats reach only the granted master; the other side sees all zeros
  always_comb begin
    m0_rdata  = '0;
    m0_rresp  = RESP_OKAY;
    m0_rlast  = 1'b0;
    m0_rvalid = 1'b0;
    m1_rdata  = '0;
    m1_rresp  = RESP_OKAY;
    m1_rlast  = 1'b0;
    m1_rvalid = 1'b0;
    if (state == ARB_DATA) begin
      if (grant_id) begin
        m1_rdata  = s_rdata;
        m1_rresp  = s_rresp;
        m1_rlast  = s_rlast;
        m1_rvalid = s_rvalid;
      end else begin
        m0_rdata  = s_rdata;
        m0_rresp  = s_rresp;
        m0_rlast  = s_rlast;
        m0_rvalid = s_rvalid;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      grant_id   <= 1'b0;
      last_grant <= 1'b1;
      beats_left <= '0;
      burst_err  <= 1'b0;
    end else begin
      if (state == ARB_IDLE && rr_valid) begin
        grant_id   <= rr_id;
        beats_left <= BEATS_WIDTH'({1'b0, (rr_id ? m1_arlen : m0_arlen)}) + BEATS_WIDTH'(1);
      end
      if (r_hs) begin
        // Saturate so an overrunning burst cannot wrap the counter
        if (beats_left != '0) beats_left <= beats_left - BEATS_WIDTH'(1);
        if ((s_rlast && beats_left != BEATS_WIDTH'(1)) ||
            (!s_rlast && beats_left == BEATS_WIDTH'(1)))
          burst_err <= 1'b1;
        if (s_rlast) last_grant <= grant_id;
      end
    end
  end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Scoreboard bench for axi_read_arbiter: expected grants and R beats are queued when
// requests are issued and popped as the arbiter forwards AR handshakes and R beats.
`timescale 1ns/1ps
module tb_axi_read_arbiter;
  import axi_pkg::*;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;

  typedef struct {
    logic       id;
    logic [7:0] addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
  } req_t;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [AW-1:0] m0_araddr, m1_araddr, s_araddr;
  logic [7:0]    m0_arlen, m1_arlen, s_arlen;
  logic [2:0]    m0_arsize, m1_arsize, s_arsize;
  logic [1:0]    m0_arburst, m1_arburst, s_arburst;
  logic          m0_arvalid, m1_arvalid, m0_arready, m1_arready;
  logic [DW-1:0] m0_rdata, m1_rdata, s_rdata;
  logic [1:0]    m0_rresp, m1_rresp, s_rresp;
  logic          m0_rlast, m1_rlast, m0_rvalid, m1_rvalid, m0_rready, m1_rready;
  logic          s_arvalid, s_arready, s_rlast, s_rvalid, s_rready;
  logic          grant_id, busy, burst_err;

  int    n_cmp = 0;
  int    n_mis = 0;
  req_t  rq0[$], rq1[$], gq[$];
  beat_t eq0[$], eq1[$];
  int    inj_last = -1;
  logic  bp_on = 1'b0;
  int    idle_m = -1;

  always #5 aclk = ~aclk;

  axi_read_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .m0_araddr(m0_araddr), .m0_arlen(m0_arlen), .m0_arsize(m0_arsize), .m0_arburst(m0_arburst),
    .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp),
    .m0_rlast(m0_rlast), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m1_araddr(m1_araddr), .m1_arlen(m1_arlen), .m1_arsize(m1_arsize), .m1_arburst(m1_arburst),
    .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp),
    .m1_rlast(m1_rlast), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .grant_id(grant_id), .busy(busy), .burst_err(burst_err)
  );

  function automatic logic [31:0] beat_data(input logic [7:0] addr, input logic [7:0] beat);
    return {16'hC0DE, addr, beat};
  endfunction

  function automatic logic [1:0] beat_resp(input logic [7:0] beat);
    return beat[0] ? RESP_SLVERR : RESP_OKAY;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Issue a request; grants are expected in the order requests are issued
  task automatic issue(input logic id, input logic [7:0] addr, input logic [7:0] len,
                       input int last_at);
    req_t  r;
    beat_t b;
    int    la;
    r.id = id; r.addr = addr; r.len = len;
    r.size  = id ? 3'd1 : 3'd2;
    r.burst = id ? BURST_WRAP : BURST_INCR;
    if (id) rq1.push_back(r); else rq0.push_back(r);
    gq.push_back(r);
    la = (last_at < 0) ? int'(len) : last_at;
    for (int k = 0; k <= la; k++) begin
      b.data = beat_data(addr, 8'(k));
      b.resp = beat_resp(8'(k));
      b.last = (k == la);
      if (id) eq1.push_back(b); else eq0.push_back(b);
    end
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while ((rq0.size() + rq1.size() + gq.size() + eq0.size() + eq1.size()) != 0 ||
           busy || m0_arvalid || m1_arvalid || s_rvalid) begin
      @(negedge aclk);
      n++;
      if (n > budget) begin
        check_eq("timeout", 32'(n), 32'(budget));
        return;
      end
    end
  endtask

  // Slave model: one burst at a time, optional rlast placed on a chosen beat
  logic       sl_busy;
  logic [7:0] sl_addr, sl_beat, sl_last;
  assign s_arready = !sl_busy;
  assign s_rvalid  = sl_busy;
  assign s_rdata   = beat_data(sl_addr, sl_beat);
  assign s_rresp   = beat_resp(sl_beat);
  assign s_rlast   = sl_busy && (sl_beat == sl_last);

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sl_busy <= 1'b0; sl_addr <= '0; sl_beat <= '0; sl_last <= '0;
    end else if (!sl_busy) begin
      if (s_arvalid) begin
        sl_busy <= 1'b1;
        sl_addr <= s_araddr;
        sl_beat <= '0;
        sl_last <= (inj_last >= 0) ? 8'(inj_last) : s_arlen;
      end
    end else if (s_rready) begin
      if (s_rlast) sl_busy <= 1'b0;
      else         sl_beat <= sl_beat + 8'd1;
    end
  end

  // Master AR drivers
  initial begin
    req_t r;
    logic hs;
    m0_arvalid = 1'b0; m0_araddr = '0; m0_arlen = '0; m0_arsize = '0; m0_arburst = '0;
    forever begin
      @(negedge aclk);
      hs = m0_arvalid && m0_arready;
      @(posedge aclk); #1;
      if (hs || !aresetn) m0_arvalid = 1'b0;
      if (!m0_arvalid && aresetn && rq0.size() > 0) begin
        r = rq0.pop_front();
        m0_araddr = r.addr; m0_arlen = r.len; m0_arsize = r.size; m0_arburst = r.burst;
        m0_arvalid = 1'b1;
      end
    end
  end

  initial begin
    req_t r;
    logic hs;
    m1_arvalid = 1'b0; m1_araddr = '0; m1_arlen = '0; m1_arsize = '0; m1_arburst = '0;
    forever begin
      @(negedge aclk);
      hs = m1_arvalid && m1_arready;
      @(posedge aclk); #1;
      if (hs || !aresetn) m1_arvalid = 1'b0;
      if (!m1_arvalid && aresetn && rq1.size() > 0) begin
        r = rq1.pop_front();
        m1_araddr = r.addr; m1_arlen = r.len; m1_arsize = r.size; m1_arburst = r.burst;
        m1_arvalid = 1'b1;
      end
    end
  end

  initial begin
    m1_rready = 1'b1;
    forever begin
      @(posedge aclk); #1;
      m1_rready = bp_on ? ~m1_rready : 1'b1;
    end
  end

  // AR handshake monitor
  always @(negedge aclk) begin
    req_t g;
    if (aresetn && s_arvalid && s_arready) begin
      if (gq.size() == 0) check_eq("unexpected_ar", 32'(s_araddr), 32'hFFFF_FFFF);
      else begin
        g = gq.pop_front();
        check_eq("grant_id", 32'(grant_id), 32'(g.id));
        check_eq("s_araddr", 32'(s_araddr), 32'(g.addr));
        check_eq("s_arlen", 32'(s_arlen), 32'(g.len));
        check_eq("s_arsize", 32'(s_arsize), 32'(g.size));
        check_eq("s_arburst", 32'(s_arburst), 32'(g.burst));
      end
    end
  end

  // R beat monitor
  always @(negedge aclk) begin
    beat_t b;
    if (aresetn) begin
      check_eq("r_exclusive", 32'(m0_rvalid & m1_rvalid), 32'd0);
      if (m0_rvalid && m0_rready) begin
        if (eq0.size() == 0) check_eq("unexpected_m0_beat", m0_rdata, 32'hFFFF_FFFF);
        else begin
          b = eq0.pop_front();
          check_eq("m0_rdata", m0_rdata, b.data);
          check_eq("m0_rresp", 32'(m0_rresp), 32'(b.resp));
          check_eq("m0_rlast", 32'(m0_rlast), 32'(b.last));
        end
      end
      if (m1_rvalid && m1_rready) begin
        if (eq1.size() == 0) check_eq("unexpected_m1_beat", m1_rdata, 32'hFFFF_FFFF);
        else begin
          b = eq1.pop_front();
          check_eq("m1_rdata", m1_rdata, b.data);
          check_eq("m1_rresp", 32'(m1_rresp), 32'(b.resp));
          check_eq("m1_rlast", 32'(m1_rlast), 32'(b.last));
        end
      end
      if (idle_m == 1) begin
        check_eq("m1_quiet_rvalid", 32'(m1_rvalid), 32'd0);
        check_eq("m1_quiet_rdata", m1_rdata, 32'd0);
      end
      if (idle_m == 0) begin
        check_eq("m0_quiet_rvalid", 32'(m0_rvalid), 32'd0);
        check_eq("m0_quiet_rdata", m0_rdata, 32'd0);
      end
      if (bp_on && s_rvalid) check_eq("s_rready_track", 32'(s_rready), 32'(m1_rready));
    end
  end

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_m0_arready"}, 32'(m0_arready), 32'd0);
    check_eq({tag, "_m1_arready"}, 32'(m1_arready), 32'd0);
    check_eq({tag, "_m0_rvalid"}, 32'(m0_rvalid), 32'd0);
    check_eq({tag, "_m1_rvalid"}, 32'(m1_rvalid), 32'd0);
    check_eq({tag, "_s_arvalid"}, 32'(s_arvalid), 32'd0);
    check_eq({tag, "_s_rready"}, 32'(s_rready), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_grant_id"}, 32'(grant_id), 32'd0);
    check_eq({tag, "_burst_err"}, 32'(burst_err), 32'd0);
  endtask

  task automatic flush_and_reset();
    rq0.delete(); rq1.delete(); gq.delete(); eq0.delete(); eq1.delete();
    aresetn = 1'b0;
    repeat (2) @(posedge aclk);
    #2;
    aresetn = 1'b1;
    @(negedge aclk);
  endtask

  initial begin
    int n;
    m0_rready = 1'b1;
    aresetn   = 1'b0;
    #1;
    check_reset_outputs("rst");
    repeat (3) @(posedge aclk);
    #2;
    aresetn = 1'b1;
    @(negedge aclk);

    // Tie straight after reset: m0 first, then m1
    issue(1'b0, 8'h20, 8'd0, -1);
    issue(1'b1, 8'h30, 8'd0, -1);
    wait_done(200);

    // Continuous requests from both: grants alternate 0,1,0,1,0,1
    for (int k = 0; k < 3; k++) begin
      issue(1'b0, 8'(8'h40 + k), 8'(k), -1);
      issue(1'b1, 8'(8'h80 + k), 8'(k + 1), -1);
    end
    wait_done(400);
    check_eq("fair_burst_err", 32'(burst_err), 32'd0);

    // Single m0 request: AR forwarded the cycle after arvalid is sampled
    idle_m = 1;
    issue(1'b0, 8'h10, 8'd3, -1);
    n = 0;
    do begin
      @(negedge aclk);
      n++;
    end while (!m0_arvalid && n < 20);
    check_eq("t1_arvalid_seen", 32'(m0_arvalid), 32'd1);
    check_eq("t1_pre_s_arvalid", 32'(s_arvalid), 32'd0);
    @(posedge aclk); #1;
    check_eq("t1_s_arvalid", 32'(s_arvalid), 32'd1);
    check_eq("t1_s_araddr", 32'(s_araddr), 32'h10);
    check_eq("t1_busy", 32'(busy), 32'd1);
    wait_done(200);
    idle_m = -1;
    check_eq("t1_burst_err", 32'(burst_err), 32'd0);

    // m1 burst under toggling rready
    idle_m = 0;
    bp_on  = 1'b1;
    issue(1'b1, 8'h55, 8'd2, -1);
    wait_done(200);
    bp_on  = 1'b0;
    idle_m = -1;
    check_eq("t4_grant_id", 32'(grant_id), 32'd1);

    // Early rlast on the second beat of a four-beat burst
    inj_last = 1;
    issue(1'b0, 8'h60, 8'd3, 1);
    wait_done(200);
    inj_last = -1;
    check_eq("t5_burst_err", 32'(burst_err), 32'd1);
    check_eq("t5_busy", 32'(busy), 32'd0);
    issue(1'b1, 8'h61, 8'd0, -1);
    wait_done(200);
    check_eq("t5_err_sticky", 32'(burst_err), 32'd1);

    // Missing rlast: slave overruns a two-beat burst by two beats
    flush_and_reset();
    check_eq("t5b_err_cleared", 32'(burst_err), 32'd0);
    inj_last = 3;
    issue(1'b0, 8'h70, 8'd1, 3);
    wait_done(200);
    inj_last = -1;
    check_eq("t5b_burst_err", 32'(burst_err), 32'd1);
    check_eq("t5b_busy", 32'(busy), 32'd0);

    // Reset asserted while the second beat of four is on the bus
    flush_and_reset();
    issue(1'b0, 8'h90, 8'd3, -1);
    n = 0;
    while (eq0.size() > 3 && n < 100) begin
      @(negedge aclk);
      n++;
    end
    check_eq("t6_first_beat", 32'(eq0.size()), 32'd3);
    @(posedge aclk);
    @(negedge aclk);
    #2;
    check_eq("t6_pre_rvalid", 32'(m0_rvalid), 32'd1);
    aresetn = 1'b0;
    #1;
    check_reset_outputs("t6");
    rq0.delete(); rq1.delete(); gq.delete(); eq0.delete(); eq1.delete();
    repeat (2) @(posedge aclk);
    #2;
    aresetn = 1'b1;
    @(negedge aclk);
    issue(1'b1, 8'hA0, 8'd1, -1);
    wait_done(200);
    check_eq("t6_grant_id", 32'(grant_id), 32'd1);
    check_eq("t6_burst_err", 32'(burst_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
